// File: rtl/relojes_monitor_pkg.sv
// Shared definitions for the divided-clock health monitor: FSM states, cause bits and the
// default half-period lengths the divider produces.
package relojes_monitor_pkg;

  typedef enum logic [1:0] {
    StAcquire = 2'd0,
    StLocked  = 2'd1,
    StFault   = 2'd2
  } state_e;

  localparam int unsigned ErrClk4f = 0;
  localparam int unsigned ErrClk2f = 1;
  localparam int unsigned ErrClk   = 2;
  localparam int unsigned ErrAlign = 3;

  localparam int unsigned DefHalf4     = 4;
  localparam int unsigned DefHalf2     = 8;
  localparam int unsigned DefHalf1     = 16;
  localparam int unsigned DefLockEdges = 2;
  localparam int unsigned DefCw        = 6;

endpackage

// File: rtl/relojes_monitor_period_checker.sv
// Half-period checker for one divided clock: detects toggles, measures the spacing between
// them and flags a wrong spacing or a clock that stops toggling.
module relojes_monitor_period_checker
  import relojes_monitor_pkg::*;
#(
  parameter int unsigned HALF = DefHalf4,
  parameter int unsigned CW   = DefCw
) (
  input  logic clk32f,
  input  logic rst,
  input  logic clr,
  input  logic sig_in,
  output logic edge_det,
  output logic period_err
);

  localparam logic [CW-1:0] HalfC  = CW'(HALF);
  localparam logic [CW-1:0] HalfP1 = CW'(HALF + 1);

  logic          prev_q;
  logic          seen_q;
  logic [CW-1:0] cnt_q;

  assign edge_det = sig_in ^ prev_q;

  // The stuck term is true for exactly one cycle because cnt_q keeps counting past it.
  assign period_err = (edge_det && seen_q && (cnt_q != HalfC)) || (cnt_q == HalfP1);

  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= sig_in;
      if (edge_det) begin
        cnt_q <= CW'(1);
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (clr) begin
        seen_q <= 1'b0;
      end else if (edge_det) begin
        seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/relojes_monitor.sv
// Health monitor for the clk4f/clk2f/clk clocks divided from clk32f: checks half-periods and
// mutual phase alignment, reports lock, a sticky fault with its cause and a clean-edge count.
module relojes_monitor
  import relojes_monitor_pkg::*;
#(
  parameter int unsigned HALF4      = DefHalf4,
  parameter int unsigned HALF2      = DefHalf2,
  parameter int unsigned HALF1      = DefHalf1,
  parameter int unsigned LOCK_EDGES = DefLockEdges,
  parameter int unsigned CW         = DefCw
) (
  input  logic       clk32f,
  input  logic       rst,
  input  logic       clk4f_in,
  input  logic       clk2f_in,
  input  logic       clk_in,
  input  logic       clr_err,
  output logic       locked_out_c,
  output logic       error_out_c,
  output logic [3:0] err_code_out_c,
  output logic [7:0] edges_out_c
);

  state_e     state_q;
  logic [7:0] good_q;
  logic       dirty_q;
  logic       clr;
  logic       e4, e2, e1;
  logic       pe4, pe2, pe1;
  logic [3:0] v;
  logic       clean;

  assign clr = (state_q == StFault) && clr_err;

  relojes_monitor_period_checker #(.HALF(HALF4), .CW(CW)) u_chk4f (
    .clk32f     (clk32f),
    .rst        (rst),
    .clr        (clr),
    .sig_in     (clk4f_in),
    .edge_det   (e4),
    .period_err (pe4)
  );

  relojes_monitor_period_checker #(.HALF(HALF2), .CW(CW)) u_chk2f (
    .clk32f     (clk32f),
    .rst        (rst),
    .clr        (clr),
    .sig_in     (clk2f_in),
    .edge_det   (e2),
    .period_err (pe2)
  );

  relojes_monitor_period_checker #(.HALF(HALF1), .CW(CW)) u_chk1 (
    .clk32f     (clk32f),
    .rst        (rst),
    .clr        (clr),
    .sig_in     (clk_in),
    .edge_det   (e1),
    .period_err (pe1)
  );

  always_comb begin
    v           = '0;
    v[ErrClk4f] = pe4;
    v[ErrClk2f] = pe2;
    v[ErrClk]   = pe1;
    v[ErrAlign] = (e2 && !e4) || (e1 && !e2);
  end

  // dirty_q remembers any violation since the last clk_in edge.
  assign clean = e1 && (v == '0) && !dirty_q;

  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      state_q        <= StAcquire;
      good_q         <= '0;
      dirty_q        <= 1'b0;
      locked_out_c   <= 1'b0;
      error_out_c    <= 1'b0;
      err_code_out_c <= '0;
      edges_out_c    <= '0;
    end else begin
      dirty_q <= (clr || e1) ? 1'b0 : (dirty_q || (v != '0));
      unique case (state_q)
        StAcquire: begin
          if (v != '0) begin
            good_q <= '0;
          end else if (clean) begin
            if (good_q == 8'(LOCK_EDGES - 1)) begin
              state_q      <= StLocked;
              locked_out_c <= 1'b1;
              edges_out_c  <= '0;
              good_q       <= '0;
            end else begin
              good_q <= good_q + 8'd1;
            end
          end
        end
        StLocked: begin
          if (v != '0) begin
            state_q        <= StFault;
            err_code_out_c <= v;
            locked_out_c   <= 1'b0;
            error_out_c    <= 1'b1;
          end else if (clean) begin
            edges_out_c <= edges_out_c + 8'd1;
          end
        end
        StFault: begin
          if (clr_err) begin
            state_q        <= StAcquire;
            error_out_c    <= 1'b0;
            err_code_out_c <= '0;
            good_q         <= '0;
          end
        end
        default: state_q <= StAcquire;
      endcase
    end
  end

endmodule

// File: doc/relojes_monitor.md
Name: relojes_monitor

Overview:
- Consumes the three divided clocks produced from clk32f and checks them, sampled in the clk32f domain.
- Measures every half-period of each clock and checks that the clocks toggle in phase with each other.
- Reports lock, a sticky fault and a cause code.
- Sits beside the divider for self-checking and for clock-health status toward the PHY/control logic.

Parameters:
HALF4, 4, expected clk32f cycles between toggles of clk4f_in
HALF2, 8, expected clk32f cycles between toggles of clk2f_in
HALF1, 16, expected clk32f cycles between toggles of clk_in
LOCK_EDGES, 2, consecutive clean clk_in toggles required to declare lock
CW, 6, width of the per-clock interval counters; must hold HALF1+1

Ports:
clk32f  input  1  reference clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
clk4f_in  input  1  divided clock under test, fastest
clk2f_in  input  1  divided clock under test, middle
clk_in  input  1  divided clock under test, slowest
clr_err  input  1  single-cycle pulse; leaves FAULT
locked_out_c  output  1  high in LOCKED
error_out_c  output  1  high in FAULT (sticky)
err_code_out_c  output  4  latched cause: [0] clk4f period, [1] clk2f period, [2] clk period, [3] phase alignment
edges_out_c  output  8  count of clean clk_in toggles while LOCKED; wraps 255->0

Behaviour:
- Reset is asynchronous and active-high.
  - All outputs reset to 0.
  - Previous-sample registers, interval counters and seen-edge flags reset to 0.
  - FSM resets to ACQUIRE.
- Inputs are already in the clk32f domain, so no synchronizers are used.
- An edge on clock x is detected in cycle t when in_x differs from prev_x. prev_x updates every cycle.
- Interval counter cnt_x:
  - loads 1 on an edge of x;
  - otherwise increments, saturating at all-ones.
- Period violation on x:
  - an edge of x while seen_x=1 and cnt_x != HALFx; or
  - cnt_x == HALFx+1, meaning a stuck clock; this is flagged once, when cnt_x reaches HALFx+1, regardless of seen_x.
- seen_x sets on the first edge of x after reset or after entering ACQUIRE. No interval check is made before seen_x=1.
- Alignment violation:
  - an edge of clk2f_in without an edge of clk4f_in in the same cycle; or
  - an edge of clk_in without an edge of clk2f_in in the same cycle.
- A clean clk_in edge is a clk_in edge in a cycle with no violation, and with no violation since the previous clk_in edge.
- Violations in the same cycle OR together into a 4-bit vector v.
- FSM states:
  - ACQUIRE:
    - any v != 0 clears the good counter;
    - each clean clk_in edge increments it;
    - when it reaches LOCK_EDGES, go to LOCKED and clear edges_out_c.
    - error_out_c stays 0 in ACQUIRE.
  - LOCKED:
    - each clean clk_in edge increments edges_out_c;
    - v != 0 goes to FAULT: err_code_out_c <= v, locked_out_c <= 0, error_out_c <= 1.
    - clr_err is ignored.
  - FAULT:
    - outputs hold;
    - further violations do not change err_code_out_c;
    - clr_err=1 goes to ACQUIRE: error_out_c <= 0, err_code_out_c <= 0, seen flags cleared, good counter cleared.
    - A violation in the same cycle as clr_err is ignored.
- Latency:
  - all outputs are registered;
  - a violation detected in cycle t is visible on outputs after posedge t+1;
  - locked_out_c rises one cycle after the qualifying clk_in edge.
- Reset mid-operation returns to ACQUIRE immediately, without waiting for a clock edge.

Decomposition:
- Shared include relojes_defs.vh holds:
  - FSM state encodings (ACQUIRE=2'd0, LOCKED=2'd1, FAULT=2'd2);
  - err_code bit indices;
  - default HALF values, shared with the divider.
- Sub-module period_checker(clk32f, rst, clr, in, HALF):
  - outputs edge and period_err;
  - instantiated three times.
- The top level holds the alignment logic, the FSM and the edge counter.

Test Plan:
- Drive the three clocks from the team's divider after rst deassert -> locked_out_c=1 within 2*32+2 cycles after the first clk_in toggle; error_out_c=0; edges_out_c increments every 16 cycles.
- While LOCKED, stretch one clk4f_in half-period to 5 cycles -> error_out_c=1, err_code_out_c=4'b1001 (period plus misaligned clk2f edge where applicable, else 4'b0001), locked_out_c=0.
- While LOCKED, hold clk_in constant -> 17 cycles after its last toggle err_code_out_c[2]=1, error_out_c=1.
- While LOCKED, shift clk2f_in by one cycle so its toggles miss clk4f_in toggles -> err_code_out_c[3]=1 set.
- In FAULT, pulse clr_err with good clocks -> error_out_c=0, err_code_out_c=0 next cycle; relock after LOCK_EDGES clean clk_in edges.
- Assert rst asynchronously mid-LOCKED between clk32f edges -> all outputs 0 immediately; FSM is in ACQUIRE.
